// File: rtl/ds_pkg.sv
// Shared geometry and state encoding for the downsampler and its frame collector.
package ds_pkg;

  // Source image geometry and 2:1 decimation in each direction.
  localparam int unsigned DS_IN_W   = 100;
  localparam int unsigned DS_IN_H   = 76;
  localparam int unsigned DS_STEP   = 2;
  localparam int unsigned DS_OUT_W  = DS_IN_W / DS_STEP;
  localparam int unsigned DS_OUT_H  = DS_IN_H / DS_STEP;

  // Frame store and image buffer sizing.
  localparam int unsigned DS_DEPTH  = DS_OUT_W * DS_OUT_H;
  localparam int unsigned DS_AW     = $clog2(DS_DEPTH);
  localparam int unsigned DS_SRC_AW = $clog2(DS_IN_W * DS_IN_H);
  localparam int unsigned DS_RD_LAT = 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2,
    StDone    = 2'd3
  } ds_state_e;

endpackage

// File: rtl/ds_frame_ram.sv
// DEPTH x DW simple dual-port frame store, registered read-first output.
module ds_frame_ram #(
  parameter int unsigned DEPTH = 1900,
  parameter int unsigned AW    = 11,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          raddr_ok;

  // Addresses past the end of the store read back as zero.
  assign raddr_ok = {1'b0, raddr} < DepthC;

  // Write port; contents are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port; sampling mem in the same edge as a write yields the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= raddr_ok ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/ds_frame_collector.sv
// Captures pixels returned by the image buffer for each downsampler request,
// packs them into a dense frame store and checks the issued address raster.
module ds_frame_collector
  import ds_pkg::*;
#(
  parameter int unsigned IN_W   = DS_IN_W,
  parameter int unsigned OUT_W  = DS_OUT_W,
  parameter int unsigned OUT_H  = DS_OUT_H,
  parameter int unsigned DEPTH  = OUT_W * OUT_H,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned SRC_AW = DS_SRC_AW,
  parameter int unsigned RD_LAT = DS_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SRC_AW-1:0] src_addr,
  input  logic              src_addr_valid,
  input  logic [7:0]        src_data,
  input  logic              src_finished,
  input  logic [AW-1:0]     rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic [AW:0]       pix_count,
  output logic              err_overflow,
  output logic              err_seq
);

  localparam int unsigned       CW        = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0]     ColLast   = CW'(OUT_W - 1);
  localparam logic [CW-1:0]     ColOne    = CW'(1);
  localparam logic [SRC_AW-1:0] ColStep   = SRC_AW'(DS_STEP);
  // Jump from the last column of one output row to column 0 two rows down.
  localparam logic [SRC_AW-1:0] WrapStep  = SRC_AW'(DS_STEP * IN_W - DS_STEP * (OUT_W - 1));
  localparam logic [AW:0]       DepthC    = (AW+1)'(DEPTH);
  localparam logic [AW:0]       PixOne    = (AW+1)'(1);
  localparam logic [1:0]        DrainLast = 2'(RD_LAT - 1);

  ds_state_e         state_q, state_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic              clear;
  logic              accept;

  logic [RD_LAT-1:0] vld_q;
  logic              wr_due;
  logic              wr_en;

  logic [AW:0]       pix_count_q;
  logic              err_overflow_q;
  logic              err_seq_q;

  logic [SRC_AW-1:0] exp_addr_q;
  logic [CW-1:0]     col_q;

  // Next-state and per-state outputs.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    clear       = 1'b0;
    accept      = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clear   = 1'b1;
          state_d = StCollect;
        end
      end
      StCollect: begin
        busy        = 1'b1;
        accept      = src_addr_valid;
        drain_cnt_d = '0;
        if (src_finished) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (drain_cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      StDone: begin
        frame_done = 1'b1;
        if (start) begin
          clear   = 1'b1;
          state_d = StCollect;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and drain counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Read-latency tracker: one valid bit per outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (clear) begin
      vld_q <= '0;
    end else begin
      vld_q <= RD_LAT'({vld_q, accept});
    end
  end

  assign wr_due = vld_q[RD_LAT-1];
  assign wr_en  = wr_due && (pix_count_q != DepthC);

  // Pixel counter and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_count_q    <= '0;
      err_overflow_q <= 1'b0;
      err_seq_q      <= 1'b0;
    end else if (clear) begin
      pix_count_q    <= '0;
      err_overflow_q <= 1'b0;
      err_seq_q      <= 1'b0;
    end else begin
      if (wr_due) begin
        if (pix_count_q == DepthC) begin
          err_overflow_q <= 1'b1;
        end else begin
          pix_count_q <= pix_count_q + PixOne;
        end
      end
      if (accept && (src_addr != exp_addr_q)) begin
        err_seq_q <= 1'b1;
      end
    end
  end

  // Expected raster address, advanced on every accepted request even on mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_addr_q <= '0;
      col_q      <= '0;
    end else if (clear) begin
      exp_addr_q <= '0;
      col_q      <= '0;
    end else if (accept) begin
      if (col_q == ColLast) begin
        col_q      <= '0;
        exp_addr_q <= exp_addr_q + WrapStep;
      end else begin
        col_q      <= col_q + ColOne;
        exp_addr_q <= exp_addr_q + ColStep;
      end
    end
  end

  ds_frame_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (8)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (pix_count_q[AW-1:0]),
    .wdata (src_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign pix_count    = pix_count_q;
  assign err_overflow = err_overflow_q;
  assign err_seq      = err_seq_q;

endmodule
